tcu_issuer: RTL

Transmit side of the PSU→TCU timed-instruction interface. The block buffers timed instructions (opcode, timing delta, per-qubit codeword array) from the upstream scheduler in a small FIFO. It pushes them into the TCU's 2-entry time buffer only when that buffer can accept, and never drives a push while `timebuf_full` is high. It also enforces drain barriers and repairs zero-delay timing values, which the TCU's down-counter cannot represent.

---
 rtl/tcu_issuer_pkg.sv | 19 +
 rtl/issue_fifo.sv | 53 +++++
 rtl/tcu_issuer.sv | 111 +++++++++++
 3 files changed

// File: rtl/tcu_issuer_pkg.sv
// Shared widths and issuer FSM encoding for the PSU->TCU timed-instruction path.
package tcu_issuer_pkg;

  localparam int unsigned DefOpcodeBw = 8;
  localparam int unsigned DefTimeBw   = 16;
  localparam int unsigned DefNumPq    = 4;
  localparam int unsigned DefCwdBw    = 4;

  localparam logic [1:0] ISSUER_IDLE  = 2'd0;
  localparam logic [1:0] ISSUER_ISSUE = 2'd1;
  localparam logic [1:0] ISSUER_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ISSUER_IDLE,
    StIssue = ISSUER_ISSUE,
    StDrain = ISSUER_DRAIN
  } issuer_state_e;

endpackage

// File: rtl/issue_fifo.sv
// First-word-fall-through FIFO; head data reads as zero while empty.
module issue_fifo #(
  parameter int unsigned Width  = 8,
  parameter int unsigned AddrBw = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [Width-1:0]  wdata_i,
  output logic [Width-1:0]  rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AddrBw:0]   count_o
);

  localparam int unsigned Depth = 1 << AddrBw;

  logic [Width-1:0]  mem_q [Depth];
  logic [AddrBw-1:0] wptr_q, rptr_q;
  logic [AddrBw:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AddrBw + 1)'(Depth));
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  // A pop frees the head slot this cycle, so a push into a full FIFO is fine.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q + (AddrBw + 1)'(do_push) - (AddrBw + 1)'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tcu_issuer.sv
// Buffers timed instructions and pushes them into the TCU time buffer, honouring
// drain barriers and clamping zero timing deltas to one.
module tcu_issuer
  import tcu_issuer_pkg::*;
#(
  parameter int unsigned OPCODE_BW = DefOpcodeBw,
  parameter int unsigned TIME_BW   = DefTimeBw,
  parameter int unsigned NUM_PQ    = DefNumPq,
  parameter int unsigned CWD_BW    = DefCwdBw,
  parameter int unsigned ADDR_BW   = 2,
  parameter int unsigned CNT_BW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_BW-1:0]     in_opcode,
  input  logic [TIME_BW-1:0]       in_timing,
  input  logic                     in_barrier,
  input  logic [NUM_PQ*CWD_BW-1:0] in_cwdarray,
  input  logic                     timebuf_full,
  input  logic                     timebuf_empty,
  output logic                     psu_valid,
  output logic [OPCODE_BW-1:0]     opcode_out,
  output logic [TIME_BW-1:0]       timing_out,
  output logic [NUM_PQ*CWD_BW-1:0] cwdarray_out,
  output logic                     busy,
  output logic                     err_zero_timing,
  output logic [CNT_BW-1:0]        issued_cnt
);

  localparam int unsigned CwdW   = NUM_PQ * CWD_BW;
  localparam int unsigned EntryW = 1 + OPCODE_BW + TIME_BW + CwdW;

  issuer_state_e       state_q, state_d;
  logic [CNT_BW-1:0]   issued_cnt_q;
  logic                err_q;

  logic                fifo_push, fifo_full, fifo_empty;
  logic [ADDR_BW:0]    fifo_count;
  logic [EntryW-1:0]   wdata, rdata;
  logic                zero_timing, head_barrier, last_entry;
  logic [TIME_BW-1:0]  timing_clamped;

  assign zero_timing    = (in_timing == '0);
  assign timing_clamped = zero_timing ? TIME_BW'(1) : in_timing;
  assign in_ready       = ~fifo_full;
  assign fifo_push      = in_valid & in_ready;
  assign wdata          = {in_barrier, in_opcode, timing_clamped, in_cwdarray};

  assign {head_barrier, opcode_out, timing_out, cwdarray_out} = rdata;
  assign last_entry = (fifo_count == (ADDR_BW + 1)'(1));

  issue_fifo #(
    .Width  (EntryW),
    .AddrBw (ADDR_BW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (fifo_push),
    .pop_i   (psu_valid),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Leaving IDLE on the accepting edge lets the head issue in the very next cycle.
  always_comb begin
    state_d   = state_q;
    psu_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fifo_push || !fifo_empty) state_d = StIssue;
      end
      StIssue: begin
        if (fifo_empty) begin
          if (!fifo_push) state_d = StIdle;
        end else if (head_barrier && !timebuf_empty) begin
          state_d = StDrain;
        end else begin
          psu_valid = head_barrier | ~timebuf_full;
          if (psu_valid && last_entry && !fifo_push) state_d = StIdle;
        end
      end
      StDrain: begin
        psu_valid = timebuf_empty & ~fifo_empty;
        if (psu_valid) state_d = (last_entry && !fifo_push) ? StIdle : StIssue;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      issued_cnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      issued_cnt_q <= issued_cnt_q + CNT_BW'(psu_valid);
      err_q        <= err_q | (fifo_push & zero_timing);
    end
  end

  assign busy            = ~fifo_empty | (state_q != StIdle);
  assign err_zero_timing = err_q;
  assign issued_cnt      = issued_cnt_q;

endmodule
